// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection and front-end boot/run/flush/halt sequencing
// Optional redirect statistics counter enabled by defining PC_SEQ_STATS_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic        pc_write_en,
    output logic [31:0] pc_next,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic        fetch_kill,
    input  logic        stall,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_vector,
    input  logic        halt_req,
`ifdef PC_SEQ_STATS_EN
    output logic [15:0] redirect_cnt,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALTED} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam state_t     POST_REDIRECT = (FLUSH_CYCLES == 0) ? RUN : FLUSH;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  flush_cnt;
    logic [3:0]  flush_cnt_nxt;
    logic        redirect_taken;
    logic [31:0] redirect_target;

    function automatic logic [31:0] align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Exceptions outrank mispredict redirects when both arrive together.
    assign redirect_target = exc_valid ? exc_vector : redir_target;

    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = flush_cnt;
        pc_write_en    = 1'b0;
        pc_next        = align(pc_cur);
        fetch_valid    = 1'b0;
        fetch_kill     = 1'b0;
        halted         = 1'b0;
        redirect_taken = 1'b0;
        if (!rst) begin
            halted = (state == HALTED);
            if (state == BOOT) begin
                pc_write_en   = 1'b1;
                pc_next       = align(RESET_VEC);
                fetch_kill    = 1'b1;
                flush_cnt_nxt = FLUSH_INIT;
                state_nxt     = POST_REDIRECT;
            end else if (exc_valid || redir_valid) begin
                redirect_taken = 1'b1;
                pc_write_en    = 1'b1;
                pc_next        = align(redirect_target);
                fetch_kill     = 1'b1;
                flush_cnt_nxt  = FLUSH_INIT;
                state_nxt      = POST_REDIRECT;
            end else begin
                case (state)
                    RUN: begin
                        fetch_valid = !stall;
                        if (!stall && fetch_ready) begin
                            pc_write_en = 1'b1;
                            pc_next     = pred_taken ? align(pred_target) : align(pc_cur + 32'd4);
                        end
                        if (halt_req) begin
                            state_nxt = HALTED;
                        end
                    end
                    FLUSH: begin
                        flush_cnt_nxt = flush_cnt - 4'd1;
                        if (flush_cnt <= 4'd1) begin
                            state_nxt = RUN;
                        end
                    end
                    default: begin
                        state_nxt = state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            flush_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

`ifdef PC_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt <= 16'd0;
        end else if (redirect_taken && redirect_cnt != 16'hFFFF) begin
            redirect_cnt <= redirect_cnt + 16'd1;
        end
    end
`endif

endmodule
